// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ requesters.
// Define UART_ARB_LOCK_EN to keep a requester's packet contiguous until its req_last byte.
//
// state   | meaning
// ARB     | idle, choosing the next requester
// SEND    | offering the held byte until tx_ready accepts it
// WAIT_LO | waiting for the transmitter to report busy
// WAIT_HI | waiting for the transmitter to become idle again
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           uart_out,
    output logic                 uart_out_valid,
    input  logic                 tx_ready,
    output logic                 busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_served;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] eligible;
    logic [7:0]         hold_data;
    logic               capture;
    logic               release_grant;

`ifdef UART_ARB_LOCK_EN
    logic lock_q;

    // A locked requester is the only candidate until its packet ends.
    assign eligible      = lock_q ? (req_valid & grant) : req_valid;
    assign release_grant = !lock_q;
`else
    logic unused_req_last;

    assign unused_req_last = ^req_last;
    assign eligible        = req_valid;
    assign release_grant   = 1'b1;
`endif

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_served) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ARB: begin
                if (win_found) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:    if (tx_ready)  state_nxt = WAIT_LO;
            WAIT_LO: if (!tx_ready) state_nxt = WAIT_HI;
            WAIT_HI: if (tx_ready)  state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    assign req_ready      = (capture && !rst) ? win_onehot : '0;
    assign uart_out_valid = (state == SEND);
    assign busy           = (state != ARB);
    assign uart_out       = hold_data;

    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data   <= 8'h00;
            grant       <= '0;
            last_served <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else if (capture) begin
            hold_data   <= req_data[{win_idx, 3'b000} +: 8];
            grant       <= win_onehot;
            last_served <= win_idx;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= !req_last[win_idx];
`endif
        end else if (state == WAIT_HI && tx_ready && release_grant) begin
            grant <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/UART models drive traffic,
// expected transfers are queued at stimulus time and checked by a negedge monitor.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     uart_out;
    logic           uart_out_valid;
    logic           tx_ready = 1'b1;
    logic           busy;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .grant          (grant),
        .uart_out       (uart_out),
        .uart_out_valid (uart_out_valid),
        .tx_ready       (tx_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;

    logic [8:0] src_mem [N][8];
    int         src_head [N];
    int         src_tail [N];
    logic [N-1:0] rdy_seen = '0;
    int         rdy_cnt [N];

    logic       stall = 1'b0;
    int         tx_cnt = 0;
    bit         xfer_seen = 1'b0;
    bit         prev_xfer = 1'b0;
    int         stall_cnt = 0;
    int         xfer_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic push_src(input int i, input logic last, input logic [7:0] d);
        src_mem[i][src_tail[i]] = {last, d};
        src_tail[i]++;
    endtask

    task automatic expect_xfer(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back('{grant: g, data: d});
    endtask

    // Requester model: holds its byte until it sees req_ready, then presents the next one.
    always @(negedge clk) rdy_seen = req_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy_seen[i] && src_head[i] < src_tail[i]) src_head[i]++;
            if (src_head[i] < src_tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                req_last[i]        = src_mem[i][src_head[i]][8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // UART model: busy for three cycles after each accepted byte; stall forces it busy.
    always @(negedge clk) xfer_seen = uart_out_valid && tx_ready;

    always @(posedge clk) begin
        #1;
        if (xfer_seen)       tx_cnt = 3;
        else if (tx_cnt > 0) tx_cnt--;
        tx_ready = (tx_cnt == 0) && !stall;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_xfer = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check("rdy_onehot", 32'($countones(req_ready)), 32'd1);
                check("rdy_only_in_arb", 32'(busy), 32'd0);
                for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
            end
            if (prev_xfer) check("valid_one_cycle", 32'(uart_out_valid), 32'd0);
            if (uart_out_valid && !tx_ready) stall_cnt++;
            if (uart_out_valid && tx_ready) begin
                xfer_total++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL xfer_unexpected: got byte %0h with nothing expected", uart_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_data", 32'(uart_out), 32'(e.data));
                    check("xfer_grant", 32'(grant), 32'(e.grant));
                end
            end
            prev_xfer = uart_out_valid && tx_ready;
        end
    end

    task automatic start_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    endtask

    task automatic end_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((exp_q.size() != 0 || busy) && k < 300);
        repeat (4) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int x0;
        int r3;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
            rdy_cnt[i]  = 0;
        end

        // Reset state, with a pending request that reset must hold off.
        start_reset();
        push_src(0, 1'b1, 8'h41);
        expect_xfer(4'b0001, 8'h41);
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(uart_out_valid), 32'd0);
        check("rst_uart_out", 32'(uart_out), 32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("single_req_ready", 32'(req_ready), 32'b0001);
        wait_idle("single_drain");

        // Fairness from reset: requester 0 first, then strict rotation.
        start_reset();
        push_src(0, 1'b1, 8'hA0);
        push_src(0, 1'b1, 8'hA0);
        push_src(1, 1'b1, 8'hA1);
        push_src(2, 1'b1, 8'hA2);
        push_src(3, 1'b1, 8'hA3);
        expect_xfer(4'b0001, 8'hA0);
        expect_xfer(4'b0010, 8'hA1);
        expect_xfer(4'b0100, 8'hA2);
        expect_xfer(4'b1000, 8'hA3);
        expect_xfer(4'b0001, 8'hA0);
        end_reset();
        wait_idle("fair_drain");

        // Backpressure: ten stalled cycles, then exactly one transfer.
        start_reset();
        stall = 1'b1;
        push_src(2, 1'b1, 8'h5C);
        expect_xfer(4'b0100, 8'h5C);
        end_reset();
        x0 = xfer_total;
        stall_cnt = 0;
        wait_busy();
        repeat (9) @(negedge clk);
        stall = 1'b0;
        wait_idle("bp_drain");
        repeat (10) @(negedge clk);
        check("bp_stall_cycles", 32'(stall_cnt), 32'd10);
        check("bp_xfer_count", 32'(xfer_total - x0), 32'd1);

        // Reset while SEND is stalled discards the byte; requester 0 wins afterwards.
        start_reset();
        stall = 1'b1;
        push_src(1, 1'b1, 8'h77);
        end_reset();
        wait_busy();
        rst = 1'b1;
        push_src(0, 1'b1, 8'h88);
        push_src(1, 1'b1, 8'h99);
        @(negedge clk);
        check("midrst_valid", 32'(uart_out_valid), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_uart_out", 32'(uart_out), 32'h00);
        expect_xfer(4'b0001, 8'h88);
        expect_xfer(4'b0010, 8'h99);
        stall = 1'b0;
        rst = 1'b0;
        wait_idle("midrst_drain");

        // Requester 3 withdraws before being granted.
        start_reset();
        stall = 1'b1;
        push_src(0, 1'b1, 8'h10);
        push_src(3, 1'b1, 8'hEE);
        expect_xfer(4'b0001, 8'h10);
        end_reset();
        r3 = rdy_cnt[3];
        wait_busy();
        src_head[3] = src_tail[3];
        @(negedge clk);
        stall = 1'b0;
        wait_idle("drop_drain");
        check("drop_no_ready3", 32'(rdy_cnt[3] - r3), 32'd0);

        // Three-byte packet from requester 1 competing with requester 2.
        start_reset();
        push_src(1, 1'b0, 8'hB1);
        push_src(1, 1'b0, 8'hB2);
        push_src(1, 1'b1, 8'hB3);
        push_src(2, 1'b1, 8'hC1);
`ifdef UART_ARB_LOCK_EN
        expect_xfer(4'b0010, 8'hB1);
        expect_xfer(4'b0010, 8'hB2);
        expect_xfer(4'b0010, 8'hB3);
        expect_xfer(4'b0100, 8'hC1);
`else
        expect_xfer(4'b0010, 8'hB1);
        expect_xfer(4'b0100, 8'hC1);
        expect_xfer(4'b0010, 8'hB2);
        expect_xfer(4'b0010, 8'hB3);
`endif
        end_reset();
        wait_idle("pkt_drain");
        check("pkt_grant_idle", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter; legal range 2..8.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_data  input  NUM_REQ*8  byte from requester i on bits [8i+7:8i].
REQ-005 req_valid  input  NUM_REQ  requester i has a byte pending; held with req_data stable until req_ready[i].
REQ-006 req_last  input  NUM_REQ  marks the pending byte of requester i as the last byte of its packet.
REQ-007 req_ready  output  NUM_REQ  one-cycle pulse: byte of requester i captured this cycle.
REQ-008 grant  output  NUM_REQ  one-hot; the requester owning the transmitter, all-zero when idle.
REQ-009 uart_out  output  8  byte to the UART transmitter.
REQ-010 uart_out_valid  output  1  byte offer to the UART transmitter.
REQ-011 tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-012 busy  output  1  high whenever the state is not ARB.

Function
REQ-013 FSM states: ARB, SEND, WAIT_LO, WAIT_HI.
REQ-014 ARB: if any eligible req_valid, select a winner round-robin, pulse req_ready[winner], capture its byte and req_last into holding registers, set grant, and go to SEND; otherwise remain in ARB.
REQ-015 Round-robin: search starts at (last_served+1) mod NUM_REQ and proceeds upward with wrap; last_served updates on every capture.
REQ-016 SEND: uart_out = held byte, uart_out_valid = 1 while tx_ready = 0; in the first cycle tx_ready = 1 is the transfer, then go to WAIT_LO with uart_out_valid = 0 next cycle.
REQ-017 Exactly one uart_out_valid&&tx_ready cycle occurs per captured byte.
REQ-018 WAIT_LO: remain until tx_ready = 0, then WAIT_HI; WAIT_HI: remain until tx_ready = 1, then ARB.
REQ-019 Minimum latency: capture cycle N, transfer at N+1 if tx_ready = 1; next capture no earlier than after tx_ready falls and rises again.
REQ-020 uart_out holds the last transferred byte outside SEND; uart_out_valid is 0 in all states except SEND.
REQ-021 req_ready is never asserted outside ARB and never to more than one requester per cycle.
REQ-022 grant stays set from capture until return to ARB (lock mode: see REQ-026); changes on req_valid while not in ARB are ignored.
REQ-023 A requester dropping req_valid before its req_ready loses nothing and is simply skipped.

Reset
REQ-024 On rst: state ARB, req_ready = 0, grant = 0, uart_out = 8'h00, uart_out_valid = 0, busy = 0, last_served = NUM_REQ-1 (requester 0 first), lock cleared; a byte in flight is discarded, uart_out_valid low the cycle after rst.
REQ-025 rst overrides all other inputs in the same cycle.

Configuration
REQ-026 With UART_ARB_LOCK_EN defined: after a byte with req_last = 0 is captured, only that requester is eligible in ARB and grant stays set until a byte with req_last = 1 has been transferred (packet atomicity, no timeout).
REQ-027 Without UART_ARB_LOCK_EN: req_last is ignored, every ARB entry re-arbitrates per byte, and grant clears on return to ARB.

Verification
REQ-028 Single: tx_ready = 1, req_valid = 4'b0001, data 8'h41 -> req_ready[0] pulse, next cycle uart_out = 8'h41 with uart_out_valid for exactly one cycle.
REQ-029 Fairness: all four valid continuously, bytes 8'hA0..8'hA3, lock off -> transfer order A0, A1, A2, A3, A0.
REQ-030 Backpressure: tx_ready = 0 for 10 cycles after capture -> uart_out_valid held 10 cycles, exactly one transfer when tx_ready rises, no second transfer.
REQ-031 Lock: UART_ARB_LOCK_EN, req 1 sends 3 bytes (last on third) while req 2 valid -> bytes of req 1 contiguous, req 2 served only after the third.
REQ-032 Reset mid-SEND: rst during SEND with tx_ready = 0 -> uart_out_valid = 0, grant = 0, busy = 0 next cycle; then requester 0 wins first.
REQ-033 Drop: req 3 deasserts req_valid before grant -> skipped, no req_ready[3], no transfer of its byte.
